// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: writeback requests, register-file write port and hazard lookup of wb_arbiter
interface wb_arbiter_if #(parameter int DW = 16, parameter int AW = 4);
  logic          a_valid;
  logic [AW-1:0] a_dst;
  logic [DW-1:0] a_data;
  logic          a_r15_we;
  logic [DW-1:0] a_r15_data;
  logic          a_ready;
  logic          b_valid;
  logic [AW-1:0] b_dst;
  logic [DW-1:0] b_data;
  logic          b_ready;
  logic          stall;
  logic          wr;
  logic          wrR15;
  logic [AW-1:0] regDst;
  logic [DW-1:0] regDstData;
  logic [DW-1:0] regR15Data;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic          pend1;
  logic          pend2;
  modport slave (
    input  a_valid, a_dst, a_data, a_r15_we, a_r15_data, b_valid, b_dst, b_data, stall, rd_addr1, rd_addr2,
    output a_ready, b_ready, wr, wrR15, regDst, regDstData, regR15Data, pend1, pend2
  );
  modport master (
    output a_valid, a_dst, a_data, a_r15_we, a_r15_data, b_valid, b_dst, b_data, stall, rd_addr1, rd_addr2,
    input  a_ready, b_ready, wr, wrR15, regDst, regDstData, regR15Data, pend1, pend2
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin merge of ALU and memory writebacks into one register-file write port
module wb_arbiter #(parameter int DW = 16, parameter int AW = 4) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  typedef enum logic {PRI_A, PRI_B} pri_t;
  localparam logic [AW-1:0] R15 = AW'(15);
  pri_t pri, priNext;
  logic grantA, grantB;
  always_comb begin
    grantA = 1'b0;
    grantB = 1'b0;
    if (rst && !bus.stall) begin
      grantA = bus.a_valid && (!bus.b_valid || pri == PRI_A);
      grantB = bus.b_valid && (!bus.a_valid || pri == PRI_B);
    end
    priNext = grantA ? PRI_B : grantB ? PRI_A : pri;
  end
  assign bus.a_ready = grantA;
  assign bus.b_ready = grantB;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pri            <= PRI_A;
      bus.wr         <= 1'b0;
      bus.wrR15      <= 1'b0;
      bus.regDst     <= '0;
      bus.regDstData <= {DW{1'b0}};
      bus.regR15Data <= {DW{1'b0}};
    end else begin
      pri       <= priNext;
      bus.wr    <= grantA ? bus.a_dst != '0 : grantB && bus.b_dst != '0;
      // a destination of R15 already carries the result, so the upper write is dropped
      bus.wrR15 <= grantA && bus.a_r15_we && bus.a_dst != R15;
      if (grantA || grantB) begin
        bus.regDst     <= grantA ? bus.a_dst : bus.b_dst;
        bus.regDstData <= grantA ? bus.a_data : bus.b_data;
      end
      if (grantA) bus.regR15Data <= bus.a_r15_data;
    end
  assign bus.pend1 = (bus.wr && bus.regDst == bus.rd_addr1) || (bus.wrR15 && bus.rd_addr1 == R15);
  assign bus.pend2 = (bus.wr && bus.regDst == bus.rd_addr2) || (bus.wrR15 && bus.rd_addr2 == R15);
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vector table, reset corner cases and random traffic against a reference model
module tb_wb_arbiter;
  logic clk, rst;
  wb_arbiter_if #(.DW(16), .AW(4)) bus ();
  wb_arbiter #(.DW(16), .AW(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic av; logic [3:0] ad; logic [15:0] adat; logic awe; logic [15:0] ar15;
    logic bv; logic [3:0] bd; logic [15:0] bdat; logic st; logic [3:0] rd1; logic [3:0] rd2;
    logic eAr; logic eBr; logic eP1; logic eP2;
    logic eWr; logic eWr15; logic [3:0] eDst; logic [15:0] eDat; logic [15:0] eR15;
  } vec_t;
  vec_t vecs[13];
  int nVec = 0, nErr = 0;
  // reference model: last granted side ("B" after reset so A is preferred) and expected outputs
  string lastGrant;
  bit mWr, mWr15;
  logic [3:0] mDst;
  logic [15:0] mData, mR15;
  bit accA, accB;
  logic gotAr, gotBr, gotP1, gotP2;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic modelReset();
    lastGrant = "B";
    mWr = 0; mWr15 = 0; mDst = 0; mData = 0; mR15 = 0;
  endtask
  task automatic cycle(input logic av, input logic [3:0] ad, input logic [15:0] adat, input logic awe,
                       input logic [15:0] ar15, input logic bv, input logic [3:0] bd, input logic [15:0] bdat,
                       input logic st, input logic [3:0] rd1, input logic [3:0] rd2);
    bit eA, eB, e1, e2;
    bus.a_valid = av; bus.a_dst = ad; bus.a_data = adat; bus.a_r15_we = awe; bus.a_r15_data = ar15;
    bus.b_valid = bv; bus.b_dst = bd; bus.b_data = bdat; bus.stall = st;
    bus.rd_addr1 = rd1; bus.rd_addr2 = rd2;
    #1;
    eA = rst && !st && av && (!bv || lastGrant == "B");
    eB = rst && !st && bv && (!av || lastGrant == "A");
    e1 = (mWr && mDst == rd1) || (mWr15 && rd1 == 4'd15);
    e2 = (mWr && mDst == rd2) || (mWr15 && rd2 == 4'd15);
    gotAr = bus.a_ready; gotBr = bus.b_ready; gotP1 = bus.pend1; gotP2 = bus.pend2;
    chk("a_ready", gotAr, eA);
    chk("b_ready", gotBr, eB);
    chk("pend1", gotP1, e1);
    chk("pend2", gotP2, e2);
    @(posedge clk);
    accA = eA; accB = eB;
    if (eA) begin
      mWr = ad != 0; mWr15 = awe && ad != 15; mDst = ad; mData = adat; mR15 = ar15; lastGrant = "A";
    end else if (eB) begin
      mWr = bd != 0; mWr15 = 0; mDst = bd; mData = bdat; lastGrant = "B";
    end else begin
      mWr = 0; mWr15 = 0;
    end
    #1;
    chk("wr", bus.wr, mWr);
    chk("wrR15", bus.wrR15, mWr15);
    chk("regDst", bus.regDst, mDst);
    chk("regDstData", bus.regDstData, mData);
    chk("regR15Data", bus.regR15Data, mR15);
  endtask
  logic rav, rawe, rbv;
  logic [3:0] rad, rbd;
  logic [15:0] radat, rar15, rbdat;
  initial begin
    vecs[0]  = '{1,2,16'h0A02,0,0,      1,5,16'h0B05,0, 0,0, 1,0,0,0, 1,0, 2,16'h0A02,16'h0000};
    vecs[1]  = '{1,2,16'h0A02,0,0,      1,5,16'h0B05,0, 0,0, 0,1,0,0, 1,0, 5,16'h0B05,16'h0000};
    vecs[2]  = '{1,2,16'h0A02,0,0,      1,5,16'h0B05,0, 0,0, 1,0,0,0, 1,0, 2,16'h0A02,16'h0000};
    vecs[3]  = '{1,2,16'h0A02,0,0,      1,5,16'h0B05,0, 0,0, 0,1,0,0, 1,0, 5,16'h0B05,16'h0000};
    vecs[4]  = '{1,3,16'h1234,0,0,      0,0,16'h0000,0, 0,0, 1,0,0,0, 1,0, 3,16'h1234,16'h0000};
    vecs[5]  = '{1,0,16'h5555,1,16'hBEEF,0,0,16'h0000,0, 0,0, 1,0,0,0, 0,1, 0,16'h5555,16'hBEEF};
    vecs[6]  = '{1,15,16'h7777,1,16'h9999,0,0,16'h0000,0, 15,0, 1,0,1,0, 1,0, 15,16'h7777,16'h9999};
    vecs[7]  = '{1,2,16'h0A02,0,0,      1,5,16'h0B05,1, 15,3, 0,0,1,0, 0,0, 15,16'h7777,16'h9999};
    vecs[8]  = '{1,2,16'h0A02,0,0,      1,5,16'h0B05,1, 0,0, 0,0,0,0, 0,0, 15,16'h7777,16'h9999};
    vecs[9]  = '{1,2,16'h0A02,0,0,      1,5,16'h0B05,1, 0,0, 0,0,0,0, 0,0, 15,16'h7777,16'h9999};
    vecs[10] = '{1,2,16'h0A02,0,0,      1,5,16'h0B05,0, 0,0, 0,1,0,0, 1,0, 5,16'h0B05,16'h9999};
    vecs[11] = '{0,0,16'h0000,0,0,      0,0,16'h0000,0, 5,4, 0,0,1,0, 0,0, 5,16'h0B05,16'h9999};
    vecs[12] = '{0,0,16'h0000,0,0,      1,0,16'h1111,0, 0,0, 0,1,0,0, 0,0, 0,16'h1111,16'h9999};
    modelReset();
    rst = 1'b0;
    bus.a_valid = 1; bus.a_dst = 3; bus.a_data = 16'h1234; bus.a_r15_we = 1; bus.a_r15_data = 16'hFFFF;
    bus.b_valid = 1; bus.b_dst = 4; bus.b_data = 16'h4444; bus.stall = 0; bus.rd_addr1 = 0; bus.rd_addr2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_ready", bus.a_ready, 0);
    chk("rst_b_ready", bus.b_ready, 0);
    chk("rst_wr", bus.wr, 0);
    chk("rst_wrR15", bus.wrR15, 0);
    chk("rst_regDst", bus.regDst, 0);
    chk("rst_regDstData", bus.regDstData, 0);
    chk("rst_regR15Data", bus.regR15Data, 0);
    #2 rst = 1'b1;
    foreach (vecs[i]) begin
      cycle(vecs[i].av, vecs[i].ad, vecs[i].adat, vecs[i].awe, vecs[i].ar15,
            vecs[i].bv, vecs[i].bd, vecs[i].bdat, vecs[i].st, vecs[i].rd1, vecs[i].rd2);
      chk($sformatf("tbl%0d_a_ready", i), gotAr, vecs[i].eAr);
      chk($sformatf("tbl%0d_b_ready", i), gotBr, vecs[i].eBr);
      chk($sformatf("tbl%0d_pend1", i), gotP1, vecs[i].eP1);
      chk($sformatf("tbl%0d_pend2", i), gotP2, vecs[i].eP2);
      chk($sformatf("tbl%0d_wr", i), bus.wr, vecs[i].eWr);
      chk($sformatf("tbl%0d_wrR15", i), bus.wrR15, vecs[i].eWr15);
      chk($sformatf("tbl%0d_regDst", i), bus.regDst, vecs[i].eDst);
      chk($sformatf("tbl%0d_regDstData", i), bus.regDstData, vecs[i].eDat);
      chk($sformatf("tbl%0d_regR15Data", i), bus.regR15Data, vecs[i].eR15);
    end
    // reset arriving mid-cycle while a write is on the port
    cycle(1, 9, 16'h0909, 1, 16'hA5A5, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_wr", bus.wr, 1);
    #2 rst = 1'b0;
    #1;
    modelReset();
    chk("async_rst_wr", bus.wr, 0);
    chk("async_rst_wrR15", bus.wrR15, 0);
    chk("async_rst_regDst", bus.regDst, 0);
    chk("async_rst_regDstData", bus.regDstData, 0);
    chk("async_rst_regR15Data", bus.regR15Data, 0);
    chk("async_rst_a_ready", bus.a_ready, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_wr", bus.wr, 0);
    cycle(1, 6, 16'h0606, 0, 0, 1, 7, 16'h0707, 0, 0, 0);
    chk("post_rst_pri_a", gotAr, 1);
    chk("post_rst_regDst", bus.regDst, 6);
    // random traffic; a request stays stable until accepted
    rav = 0; rbv = 0; accA = 0; accB = 0;
    rad = 0; radat = 0; rawe = 0; rar15 = 0; rbd = 0; rbdat = 0;
    for (int i = 0; i < 400; i++) begin
      if (!rav || accA) begin
        rav = $urandom_range(0, 2) != 0; rad = 4'($urandom_range(0, 15)); radat = 16'($urandom);
        rawe = $urandom_range(0, 1) == 1; rar15 = 16'($urandom);
      end
      if (!rbv || accB) begin
        rbv = $urandom_range(0, 2) != 0; rbd = 4'($urandom_range(0, 15)); rbdat = 16'($urandom);
      end
      cycle(rav, rad, radat, rawe, rar15, rbv, rbd, rbdat, $urandom_range(0, 4) == 0,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
